mem_arbiter: RTL

Shares one single-port synchronous RAM between the core's instruction-fetch port and data-memory port, so the core can run from a unified memory. Sits between `core_top`'s `rom_*` / `ram_*` ports and the memory macro. Serialises accesses, returns read data with a valid pulse, and raises per-port stall requests for `pipe_ctrl`.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arb_starve_cnt.sv | 35 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: bus width defaults and
// the owner encoding of the access that is currently in flight.
package mem_arbiter_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_OWN_NONE = 2'd0,
    ARB_OWN_IF   = 2'd1,
    ARB_OWN_D    = 2'd2
  } arb_own_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the core/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arbiter_pkg::ADDR_WIDTH,
  parameter int DATA_W = mem_arbiter_pkg::DATA_WIDTH
);

  logic              if_ce_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_valid_o;
  logic              if_stallreq_o;

  logic              d_ce_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_valid_o;
  logic              d_stallreq_o;

  logic              m_ce_o;
  logic              m_we_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [DATA_W-1:0] m_wdata_o;
  logic [DATA_W-1:0] m_rdata_i;

  modport slave (
    input  if_ce_i, if_addr_i, d_ce_i, d_we_i, d_addr_i, d_wdata_i, m_rdata_i,
    output if_data_o, if_valid_o, if_stallreq_o,
           d_rdata_o, d_valid_o, d_stallreq_o,
           m_ce_o, m_we_o, m_addr_o, m_wdata_o
  );

  modport master (
    output if_ce_i, if_addr_i, d_ce_i, d_we_i, d_addr_i, d_wdata_i, m_rdata_i,
    input  if_data_o, if_valid_o, if_stallreq_o,
           d_rdata_o, d_valid_o, d_stallreq_o,
           m_ce_o, m_we_o, m_addr_o, m_wdata_o
  );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of cycles the fetch port was eligible but lost arbitration.
// Only built when MEM_ARB_ANTISTARVE_EN is defined.
`ifdef MEM_ARB_ANTISTARVE_EN
module mem_arb_starve_cnt #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_eligible,
  input  logic if_granted,
  output logic force_if
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_r;

  // Count denied fetch cycles, saturating at the limit; a fetch issue clears it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r <= '0;
    end else if (if_granted) begin
      cnt_r <= '0;
    end else if (if_eligible && (cnt_r != LIMIT)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign force_if = (cnt_r == LIMIT);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data access.
// Define MEM_ARB_ANTISTARVE_EN to let a starved fetch win over data once per limit.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_WIDTH,
  parameter int DATA_W       = DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  arb_own_e          owner_r;
  arb_own_e          grant_s;
  logic              if_out_r;
  logic              d_out_r;
  logic              d_rd_r;
  logic [DATA_W-1:0] if_hold_r;
  logic [DATA_W-1:0] d_hold_r;

  logic              if_elig_s;
  logic              d_elig_s;
  logic              if_valid_s;
  logic              d_valid_s;
  logic              force_if_s;
  logic              m_ce_s;
  logic              m_we_s;
  logic [ADDR_W-1:0] m_addr_s;
  logic [DATA_W-1:0] m_wdata_s;

  assign if_valid_s = (owner_r == ARB_OWN_IF);
  assign d_valid_s  = (owner_r == ARB_OWN_D);

  // Gating with rst_i keeps every output quiet while reset is held.
  assign if_elig_s = rst_i & bus.if_ce_i & ~if_out_r;
  assign d_elig_s  = rst_i & bus.d_ce_i  & ~d_out_r;

`ifdef MEM_ARB_ANTISTARVE_EN
  mem_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_eligible (if_elig_s),
    .if_granted  (grant_s == ARB_OWN_IF),
    .force_if    (force_if_s)
  );
`else
  assign force_if_s = 1'b0;
`endif

  // Data is the older pipeline stage, so it wins unless fetch is being forced.
  always_comb begin
    grant_s = ARB_OWN_NONE;
    if (force_if_s && if_elig_s) begin
      grant_s = ARB_OWN_IF;
    end else if (d_elig_s) begin
      grant_s = ARB_OWN_D;
    end else if (if_elig_s) begin
      grant_s = ARB_OWN_IF;
    end else begin
      grant_s = ARB_OWN_NONE;
    end
  end

  // Steer the granted port onto the memory bus; idle bus is all zeros.
  always_comb begin
    m_ce_s    = 1'b0;
    m_we_s    = 1'b0;
    m_addr_s  = '0;
    m_wdata_s = '0;
    case (grant_s)
      ARB_OWN_IF: begin
        m_ce_s   = 1'b1;
        m_addr_s = bus.if_addr_i;
      end
      ARB_OWN_D: begin
        m_ce_s    = 1'b1;
        m_we_s    = bus.d_we_i;
        m_addr_s  = bus.d_addr_i;
        m_wdata_s = bus.d_wdata_i;
      end
      default: begin
        m_ce_s    = 1'b0;
        m_we_s    = 1'b0;
        m_addr_s  = '0;
        m_wdata_s = '0;
      end
    endcase
  end

  // Owner/outstanding tracking and response capture into the hold registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_r   <= ARB_OWN_NONE;
      if_out_r  <= 1'b0;
      d_out_r   <= 1'b0;
      d_rd_r    <= 1'b0;
      if_hold_r <= '0;
      d_hold_r  <= '0;
    end else begin
      owner_r <= grant_s;

      if (grant_s == ARB_OWN_IF) begin
        if_out_r <= 1'b1;
      end else if (if_valid_s) begin
        if_out_r <= 1'b0;
      end else begin
        if_out_r <= if_out_r;
      end

      if (grant_s == ARB_OWN_D) begin
        d_out_r <= 1'b1;
        d_rd_r  <= ~bus.d_we_i;
      end else if (d_valid_s) begin
        d_out_r <= 1'b0;
        d_rd_r  <= d_rd_r;
      end else begin
        d_out_r <= d_out_r;
        d_rd_r  <= d_rd_r;
      end

      if (if_valid_s) begin
        if_hold_r <= bus.m_rdata_i;
      end else begin
        if_hold_r <= if_hold_r;
      end

      // Write completions leave the last read value in place.
      if (d_valid_s && d_rd_r) begin
        d_hold_r <= bus.m_rdata_i;
      end else begin
        d_hold_r <= d_hold_r;
      end
    end
  end

  assign bus.m_ce_o    = m_ce_s;
  assign bus.m_we_o    = m_we_s;
  assign bus.m_addr_o  = m_addr_s;
  assign bus.m_wdata_o = m_wdata_s;

  assign bus.if_valid_o    = if_valid_s;
  assign bus.if_data_o     = if_valid_s ? bus.m_rdata_i : if_hold_r;
  assign bus.if_stallreq_o = rst_i & bus.if_ce_i & ~if_valid_s;

  assign bus.d_valid_o    = d_valid_s;
  assign bus.d_rdata_o    = d_valid_s ? bus.m_rdata_i : d_hold_r;
  assign bus.d_stallreq_o = rst_i & bus.d_ce_i & ~d_valid_s;

endmodule
